nibble_deserializer: RTL and testbench

- Serial-to-parallel front end that assembles single-bit input traffic into WIDTH-bit words for the downstream 4-input reduction stage (its `a` operand).
- Uses a valid/ready handshake on both sides.
- Double-buffered: one word can be presented downstream while the next word is being shifted in.
- Sits directly upstream of the reduction gate; its m_data drives that gate's vector input.

---
 rtl/nibble_deserializer.sv | 144 ++++++++++++++
 tb/tb_nibble_deserializer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_deserializer.sv
// nibble_deserializer
//
// Serial-to-parallel front end: assembles single-bit traffic into WIDTH-bit
// words for the downstream reduction stage. The design is double-buffered.
// While one word is held on m_data, the next word is shifted into sr.
// A valid/ready handshake is used on both sides.
//
// State table:
//   state | meaning
//   FILL  | shifting bits into sr; s_ready=1
//   FULL  | complete word parked in sr, output slot busy; s_ready=0
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   s_valid  - serial bit present
//   s_bit    - serial data bit
//   s_sync   - with an accepted bit, marks it as bit 0 of a new word
//   s_ready  - a bit can be accepted this cycle
//   m_valid  - m_data holds a complete word
//   m_data   - assembled word
//   m_ready  - downstream accepts the word
//   sync_err - one-cycle pulse: a partial word was discarded by s_sync

module nibble_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_sync,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             sync_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;

    logic accept;
    logic sync_hit;
    logic word_done;
    logic slot_free;
    logic load_fill;
    logic load_full;

    assign accept    = s_valid && s_ready;
    assign sync_hit  = accept && s_sync;
    // A sync on the last bit position starts a new word instead of completing one.
    assign word_done = accept && !s_sync && (cnt == CNT_LAST);
    assign slot_free = !m_valid || m_ready;
    assign load_fill = word_done && slot_free;
    assign load_full = (state == FULL) && slot_free;

    // Next shift-register contents. On sync the stale partial word is cleared
    // so only the new bit 0 remains.
    always_comb begin
        sr_shift = sr;
        if (MSB_FIRST) begin
            if (sync_hit)
                sr_shift = {{(WIDTH-1){1'b0}}, s_bit};
            else
                sr_shift = {sr[WIDTH-2:0], s_bit};
        end else begin
            if (sync_hit)
                sr_shift = {s_bit, {(WIDTH-1){1'b0}}};
            else
                sr_shift = {s_bit, sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (word_done && !slot_free)
                    state_nxt = FULL;
            end
            FULL: begin
                if (slot_free)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            sr       <= '0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            if (accept) begin
                sr <= sr_shift;
                if (sync_hit)
                    cnt <= CW'(1);
                else if (cnt == CNT_LAST)
                    cnt <= '0;
                else
                    cnt <= cnt + CW'(1);
            end

            // Completion with a free slot bypasses sr so there is no added latency.
            if (load_fill)
                m_data <= sr_shift;
            else if (load_full)
                m_data <= sr;

            if (load_fill || load_full)
                m_valid <= 1'b1;
            else if (m_ready)
                m_valid <= 1'b0;

            sync_err <= sync_hit && (cnt != '0);
        end
    end

endmodule

// File: tb/tb_nibble_deserializer.sv
module tb_nibble_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       s_valid, s_bit, s_sync, s_ready;
    logic       m_valid, m_ready, sync_err;
    logic [3:0] m_data;

    logic       l_valid, l_bit, l_sync, l_ready;
    logic       l_mvalid, l_mready, l_err;
    logic [3:0] l_data;

    logic       w_valid, w_bit, w_sync, w_ready;
    logic       w_mvalid, w_mready, w_err;
    logic [7:0] w_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_bit(s_bit), .s_sync(s_sync), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .sync_err(sync_err)
    );

    nibble_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .s_valid(l_valid), .s_bit(l_bit), .s_sync(l_sync), .s_ready(l_ready),
        .m_valid(l_mvalid), .m_data(l_data), .m_ready(l_mready), .sync_err(l_err)
    );

    nibble_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_w8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(w_valid), .s_bit(w_bit), .s_sync(w_sync), .s_ready(w_ready),
        .m_valid(w_mvalid), .m_data(w_data), .m_ready(w_mready), .sync_err(w_err)
    );

    // Drive one bit into the main DUT for one edge; returns 1 time unit after the edge.
    task automatic put(input logic b, input logic sy);
        s_valid = 1'b1;
        s_bit   = b;
        s_sync  = sy;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        n_tests++;
        if ({m_valid, m_data, s_ready, sync_err} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_init: got v=%b d=%h rdy=%b err=%b, expected v=0 d=0 rdy=1 err=0",
                     m_valid, m_data, s_ready, sync_err);
        end
        rst_n = 1'b1;
        idle(1);

        // Hold a word with no drain, start a second one, then reset between edges.
        m_ready = 1'b0;
        put(1, 0); put(0, 0); put(1, 0); put(0, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_preload: got v=%b d=%b, expected v=1 d=1010", m_valid, m_data);
        end
        put(1, 0); put(1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || m_data !== 4'h0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b d=%b rdy=%b, expected v=0 d=0000 rdy=1",
                     m_valid, m_data, s_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        put(0, 0); put(1, 0); put(1, 0); put(0, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b0110) begin
            n_fail++;
            $display("FAIL reset_after: got v=%b d=%b, expected v=1 d=0110", m_valid, m_data);
        end
        idle(1);
    endtask

    task automatic test_basic;
        m_ready = 1'b1;
        put(1, 0); put(0, 0); put(1, 0);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: got m_valid=%b, expected 0", m_valid);
        end
        put(1, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b1011) begin
            n_fail++;
            $display("FAIL basic_word: got v=%b d=%b, expected v=1 d=1011", m_valid, m_data);
        end
        idle(1);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got m_valid=%b, expected 0", m_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] wv;
        int         rdy_bad;
        int         word_bad;
        rdy_bad  = 0;
        word_bad = 0;
        m_ready  = 1'b1;
        s_valid  = 1'b1;
        s_sync   = 1'b0;
        for (int w = 0; w < 16; w++) begin
            wv = w[3:0];
            for (int i = 3; i >= 0; i--) begin
                s_bit = wv[i];
                n_tests++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    rdy_bad++;
                    if (rdy_bad < 4)
                        $display("FAIL b2b_ready: word %0d bit %0d got s_ready=%b, expected 1", w, i, s_ready);
                end
                @(posedge clk);
                #1;
                if (i == 0) begin
                    n_tests++;
                    if (m_valid !== 1'b1 || m_data !== wv || (|m_data) !== (wv != 4'h0)) begin
                        n_fail++;
                        word_bad++;
                        if (word_bad < 4)
                            $display("FAIL b2b_word: got v=%b d=%b or=%b, expected v=1 d=%b or=%b",
                                     m_valid, m_data, |m_data, wv, (wv != 4'h0));
                    end
                end
            end
        end
        s_valid = 1'b0;
        idle(1);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got m_valid=%b, expected 0", m_valid);
        end
    endtask

    task automatic test_backpressure;
        m_ready = 1'b0;
        put(0, 0); put(0, 0); put(1, 0); put(1, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b0011) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b d=%b, expected v=1 d=0011", m_valid, m_data);
        end
        put(1, 0); put(1, 0); put(0, 0); put(0, 0);
        n_tests++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 4'b0011) begin
            n_fail++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%b, expected rdy=0 v=1 d=0011",
                     s_ready, m_valid, m_data);
        end
        idle(3);
        n_tests++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 4'b0011) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b v=%b d=%b, expected rdy=0 v=1 d=0011",
                     s_ready, m_valid, m_data);
        end
        m_ready = 1'b1;
        idle(1);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b1100 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b d=%b rdy=%b, expected v=1 d=1100 rdy=1",
                     m_valid, m_data, s_ready);
        end
        idle(1);
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got m_valid=%b, expected 0", m_valid);
        end
    endtask

    task automatic test_sync;
        m_ready = 1'b1;
        put(1, 0); put(1, 0); put(1, 1);
        n_tests++;
        if (sync_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_pulse: got sync_err=%b, expected 1", sync_err);
        end
        put(0, 0);
        n_tests++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_pulse_end: got sync_err=%b, expected 0", sync_err);
        end
        put(0, 0); put(1, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b1001) begin
            n_fail++;
            $display("FAIL sync_word: got v=%b d=%b, expected v=1 d=1001", m_valid, m_data);
        end

        // Sync at a word boundary discards nothing.
        put(1, 1);
        n_tests++;
        if (sync_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_aligned: got sync_err=%b, expected 0", sync_err);
        end
        put(0, 0); put(1, 0); put(0, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b1010) begin
            n_fail++;
            $display("FAIL sync_aligned_word: got v=%b d=%b, expected v=1 d=1010", m_valid, m_data);
        end

        // Sync on the last bit position: no word is emitted, the bit starts a new word.
        put(0, 0); put(0, 0); put(0, 0); put(1, 1);
        n_tests++;
        if (m_valid !== 1'b0 || sync_err !== 1'b1 || m_data !== 4'b1010) begin
            n_fail++;
            $display("FAIL sync_last: got v=%b err=%b d=%b, expected v=0 err=1 d=1010",
                     m_valid, sync_err, m_data);
        end
        put(1, 0); put(0, 0); put(1, 0);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 4'b1101) begin
            n_fail++;
            $display("FAIL sync_last_word: got v=%b d=%b, expected v=1 d=1101", m_valid, m_data);
        end
        idle(1);
    endtask

    task automatic test_lsb_first;
        logic [3:0] bits;
        l_mready = 1'b1;
        bits = 4'b0001;                // serial order bits[0], bits[1], ...
        for (int i = 0; i < 4; i++) begin
            l_valid = 1'b1;
            l_bit   = bits[i];
            @(posedge clk);
            #1;
        end
        l_valid = 1'b0;
        n_tests++;
        if (l_mvalid !== 1'b1 || l_data !== 4'b0001) begin
            n_fail++;
            $display("FAIL lsb_word1: got v=%b d=%b, expected v=1 d=0001", l_mvalid, l_data);
        end
        bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            l_valid = 1'b1;
            l_bit   = bits[i];
            @(posedge clk);
            #1;
        end
        l_valid = 1'b0;
        n_tests++;
        if (l_mvalid !== 1'b1 || l_data !== 4'b1011) begin
            n_fail++;
            $display("FAIL lsb_word2: got v=%b d=%b, expected v=1 d=1011", l_mvalid, l_data);
        end
    endtask

    task automatic test_width8;
        logic [7:0] bits;
        w_mready = 1'b1;
        bits = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            w_valid = 1'b1;
            w_bit   = bits[i];
            @(posedge clk);
            #1;
            if (i == 1) begin
                n_tests++;
                if (w_mvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL w8_early: got m_valid=%b, expected 0", w_mvalid);
                end
            end
        end
        w_valid = 1'b0;
        n_tests++;
        if (w_mvalid !== 1'b1 || w_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL w8_word: got v=%b d=%h, expected v=1 d=a5", w_mvalid, w_data);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0; s_bit = 1'b0; s_sync = 1'b0; m_ready = 1'b0;
        l_valid = 1'b0; l_bit = 1'b0; l_sync = 1'b0; l_mready = 1'b0;
        w_valid = 1'b0; w_bit = 1'b0; w_sync = 1'b0; w_mready = 1'b0;

        test_reset;
        test_basic;
        test_back_to_back;
        test_backpressure;
        test_sync;
        test_lsb_first;
        test_width8;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
